tv80_alu16_seq: RTL and testbench



---
 rtl/tv80_pkg.sv | 34 +++
 rtl/tv80_alu16_seq.sv | 145 ++++++++++++++
 tb/tb_tv80_alu16_seq.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tv80_pkg.sv
// Shared encodings for the 16-bit arithmetic sequencer around the tv80 ALU:
// ALU_Op codes, the 2-bit 16-bit op request code, FSM states and Mode 3 flag positions.
package tv80_pkg;

    // ALU_Op codes understood by the 8-bit tv80 ALU
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_ADC = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_SBC = 4'b0011;
    localparam logic [3:0] ALU_IDLE = 4'b0000;

    // Mode 3 flag register bit positions
    localparam int Flag_C = 4;
    localparam int Flag_H = 5;
    localparam int Flag_N = 6;
    localparam int Flag_Z = 7;

    // 16-bit operation requested by the core
    typedef enum logic [1:0] {
        OP_ADD16 = 2'b00,
        OP_ADC16 = 2'b01,
        OP_SBC16 = 2'b10,
        OP_SUB16 = 2'b11
    } start_op_t;

    // Sequencer states: wait, low byte pass, high byte pass, result held
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LO   = 2'b01,
        S_HI   = 2'b10,
        S_DONE = 2'b11
    } seq_state_t;

endpackage

// File: rtl/tv80_alu16_seq.sv
// Two-pass sequencer that performs 16-bit ADD/ADC/SBC/SUB on an external 8-bit
// tv80 ALU. The low byte runs first; its flags (carry, and Z for the Z16 chain)
// are fed back as F_In for the high byte pass. The result is held until consumed.
module tv80_alu16_seq
    import tv80_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [1:0]  start_op,
    input  logic [15:0] start_a,
    input  logic [15:0] start_b,
    input  logic [7:0]  start_f,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_q,
    output logic [7:0]  res_f,
    output logic [3:0]  alu_op,
    output logic        alu_arith16,
    output logic        alu_z16,
    output logic [7:0]  alu_busa,
    output logic [7:0]  alu_busb,
    output logic [7:0]  alu_f_in,
    input  logic [7:0]  alu_q,
    input  logic [7:0]  alu_f_out
);

    seq_state_t state;
    start_op_t  op_r;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic [7:0]  f_r;
    logic [7:0]  q_lo;
    logic [7:0]  q_hi;
    logic [7:0]  f_mid;
    logic [7:0]  res_f_r;

    // FSM with operand latches, per-pass result capture and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            op_r        <= OP_ADD16;
            a_r         <= '0;
            b_r         <= '0;
            f_r         <= '0;
            q_lo        <= '0;
            q_hi        <= '0;
            f_mid       <= '0;
            res_f_r     <= '0;
            start_ready <= 1'b1;
            res_valid   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_valid) begin
                        op_r        <= start_op_t'(start_op);
                        a_r         <= start_a;
                        b_r         <= start_b;
                        f_r         <= start_f;
                        start_ready <= 1'b0;
                        state       <= S_LO;
                    end
                end
                S_LO: begin
                    q_lo  <= alu_q;
                    f_mid <= alu_f_out;
                    state <= S_HI;
                end
                S_HI: begin
                    q_hi      <= alu_q;
                    res_f_r   <= alu_f_out;
                    res_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    res_valid   <= 1'b0;
                    start_ready <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    assign res_q = {q_hi, q_lo};
    assign res_f = res_f_r;

    // ALU drive decoded from state and latched operands only; idle values outside LO/HI
    always_comb begin
        alu_op      = ALU_IDLE;
        alu_arith16 = 1'b0;
        alu_z16     = 1'b0;
        alu_busa    = 8'h00;
        alu_busb    = 8'h00;
        alu_f_in    = 8'h00;
        case (state)
            S_LO: begin
                alu_busa = a_r[7:0];
                alu_busb = b_r[7:0];
                alu_f_in = f_r;
                case (op_r)
                    OP_ADD16: begin
                        alu_op      = ALU_ADD;
                        alu_arith16 = 1'b1;
                    end
                    OP_ADC16: alu_op = ALU_ADC;
                    OP_SBC16: alu_op = ALU_SBC;
                    OP_SUB16: alu_op = ALU_SUB;
                    default:  alu_op = ALU_IDLE;
                endcase
            end
            S_HI: begin
                alu_busa = a_r[15:8];
                alu_busb = b_r[15:8];
                alu_f_in = f_mid;
                case (op_r)
                    OP_ADD16: begin
                        alu_op      = ALU_ADC;
                        alu_arith16 = 1'b1;
                    end
                    OP_ADC16: begin
                        alu_op  = ALU_ADC;
                        alu_z16 = 1'b1;
                    end
                    OP_SBC16, OP_SUB16: begin
                        alu_op  = ALU_SBC;
                        alu_z16 = 1'b1;
                    end
                    default: alu_op = ALU_IDLE;
                endcase
            end
            default: begin
                alu_op = ALU_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tv80_alu16_seq.sv
// Directed bench for tv80_alu16_seq. A behavioural model of the 8-bit tv80 ALU
// add/subtract group answers the sequencer's ALU requests; expected 16-bit
// results and flags are hand-computed constants.
module tb_tv80_alu16_seq;
    import tv80_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic [1:0]  start_op;
    logic [15:0] start_a;
    logic [15:0] start_b;
    logic [7:0]  start_f;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_q;
    logic [7:0]  res_f;
    logic [3:0]  alu_op;
    logic        alu_arith16;
    logic        alu_z16;
    logic [7:0]  alu_busa;
    logic [7:0]  alu_busb;
    logic [7:0]  alu_f_in;
    logic [7:0]  alu_q;
    logic [7:0]  alu_f_out;

    int checks = 0;
    int failures = 0;

    tv80_alu16_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_op    (start_op),
        .start_a     (start_a),
        .start_b     (start_b),
        .start_f     (start_f),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_q       (res_q),
        .res_f       (res_f),
        .alu_op      (alu_op),
        .alu_arith16 (alu_arith16),
        .alu_z16     (alu_z16),
        .alu_busa    (alu_busa),
        .alu_busb    (alu_busb),
        .alu_f_in    (alu_f_in),
        .alu_q       (alu_q),
        .alu_f_out   (alu_f_out)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // 8-bit tv80 ALU add/sub group (ops 0-3), returns {F_Out, Q}
    function automatic logic [15:0] alu_model(input logic [3:0] op, input logic ar16,
                                              input logic z16, input logic [7:0] a,
                                              input logic [7:0] b, input logic [7:0] fi);
        logic       use_carry;
        logic       sub;
        logic       cin;
        logic [7:0] bb;
        logic [4:0] nib;
        logic [8:0] full;
        logic [7:0] fo;
        use_carry = ~op[2] & op[0];
        sub       = op[1];
        cin       = sub ^ (use_carry & fi[Flag_C]);
        bb        = sub ? ~b : b;
        nib       = {1'b0, a[3:0]} + {1'b0, bb[3:0]} + {4'b0, cin};
        full      = {1'b0, a} + {1'b0, bb} + {8'b0, cin};
        fo        = fi;
        fo[Flag_N] = sub;
        fo[Flag_C] = sub ? ~full[8] : full[8];
        fo[Flag_H] = sub ? ~nib[4] : nib[4];
        if (full[7:0] == 8'h00)
            fo[Flag_Z] = z16 ? fi[Flag_Z] : 1'b1;
        else
            fo[Flag_Z] = 1'b0;
        if (ar16)
            fo[Flag_Z] = fi[Flag_Z];
        return {fo, full[7:0]};
    endfunction

    // External ALU response to whatever the sequencer drives
    always_comb begin
        {alu_f_out, alu_q} = alu_model(alu_op, alu_arith16, alu_z16, alu_busa, alu_busb, alu_f_in);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [7:0] f);
        start_valid = valid;
        start_op    = op;
        start_a     = a;
        start_b     = b;
        start_f     = f;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleAlu(input string tag);
        checkOutput({tag, ".alu_op"}, {12'h0, alu_op}, 16'h0000);
        checkOutput({tag, ".alu_flags"}, {14'h0, alu_arith16, alu_z16}, 16'h0000);
        checkOutput({tag, ".alu_bus"}, {alu_busa, alu_busb}, 16'h0000);
        checkOutput({tag, ".alu_f_in"}, {8'h00, alu_f_in}, 16'h0000);
    endtask

    // Issue one operation and follow it through LO and HI into DONE (not consumed)
    task automatic runOp(input string tag, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [7:0] f, input logic [3:0] lo_op,
                         input logic [3:0] hi_op, input logic ar16, input logic [7:0] exp_fmid,
                         input logic [15:0] exp_q, input logic [7:0] exp_f);
        logic z_hi;
        z_hi = ~ar16;
        checkOutput({tag, ".start_ready"}, {15'h0, start_ready}, 16'h0001);
        applyStimulus(1'b1, op, a, b, f);
        tick();
        applyStimulus(1'b0, 2'b00, 16'h0000, 16'h0000, 8'h00);
        checkOutput({tag, ".lo.busy"}, {15'h0, start_ready}, 16'h0000);
        checkOutput({tag, ".lo.valid"}, {15'h0, res_valid}, 16'h0000);
        checkOutput({tag, ".lo.op"}, {12'h0, alu_op}, {12'h0, lo_op});
        checkOutput({tag, ".lo.arith16"}, {15'h0, alu_arith16}, {15'h0, ar16});
        checkOutput({tag, ".lo.z16"}, {15'h0, alu_z16}, 16'h0000);
        checkOutput({tag, ".lo.bus"}, {alu_busa, alu_busb}, {a[7:0], b[7:0]});
        checkOutput({tag, ".lo.f_in"}, {8'h00, alu_f_in}, {8'h00, f});
        tick();
        checkOutput({tag, ".hi.valid"}, {15'h0, res_valid}, 16'h0000);
        checkOutput({tag, ".hi.op"}, {12'h0, alu_op}, {12'h0, hi_op});
        checkOutput({tag, ".hi.arith16"}, {15'h0, alu_arith16}, {15'h0, ar16});
        checkOutput({tag, ".hi.z16"}, {15'h0, alu_z16}, {15'h0, z_hi});
        checkOutput({tag, ".hi.bus"}, {alu_busa, alu_busb}, {a[15:8], b[15:8]});
        checkOutput({tag, ".hi.f_in"}, {8'h00, alu_f_in}, {8'h00, exp_fmid});
        tick();
        checkOutput({tag, ".done.valid"}, {15'h0, res_valid}, 16'h0001);
        checkOutput({tag, ".done.q"}, res_q, exp_q);
        checkOutput({tag, ".done.f"}, {8'h00, res_f}, {8'h00, exp_f});
        checkOutput({tag, ".done.busy"}, {15'h0, start_ready}, 16'h0000);
        checkIdleAlu({tag, ".done"});
    endtask

    task automatic consumeResult(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checkOutput({tag, ".consumed.valid"}, {15'h0, res_valid}, 16'h0000);
        checkOutput({tag, ".consumed.ready"}, {15'h0, start_ready}, 16'h0001);
    endtask

    // Directed sequence
    initial begin
        reset     = 1'b1;
        res_ready = 1'b0;
        applyStimulus(1'b0, 2'b00, 16'h0000, 16'h0000, 8'h00);
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset.ready", {15'h0, start_ready}, 16'h0001);
        checkOutput("reset.valid", {15'h0, res_valid}, 16'h0000);
        checkOutput("reset.q", res_q, 16'h0000);
        checkOutput("reset.f", {8'h00, res_f}, 16'h0000);
        checkIdleAlu("reset");

        $display("[TB] ADD16 0FFF+0001");
        runOp("add16", 2'b00, 16'h0FFF, 16'h0001, 8'h80, 4'b0000, 4'b0001, 1'b1,
              8'hB0, 16'h1000, 8'hA0);
        consumeResult("add16");
        tick();

        $display("[TB] ADC16 00FF+0001+C");
        runOp("adc16a", 2'b01, 16'h00FF, 16'h0001, 8'h10, 4'b0001, 4'b0001, 1'b0,
              8'h30, 16'h0101, 8'h00);
        consumeResult("adc16a");
        tick();

        $display("[TB] ADC16 FFFF+0000+C");
        runOp("adc16b", 2'b01, 16'hFFFF, 16'h0000, 8'h10, 4'b0001, 4'b0001, 1'b0,
              8'hB0, 16'h0000, 8'hB0);
        consumeResult("adc16b");
        tick();

        $display("[TB] SBC16 0000-0001");
        runOp("sbc16", 2'b10, 16'h0000, 16'h0001, 8'h00, 4'b0011, 4'b0011, 1'b0,
              8'h70, 16'hFFFF, 8'h70);
        consumeResult("sbc16");
        tick();

        $display("[TB] SUB16 1234-1234");
        runOp("sub16", 2'b11, 16'h1234, 16'h1234, 8'h10, 4'b0010, 4'b0011, 1'b0,
              8'hC0, 16'h0000, 8'hC0);
        consumeResult("sub16");
        tick();

        $display("[TB] backpressure");
        runOp("bp", 2'b00, 16'h0001, 16'h0002, 8'h00, 4'b0000, 4'b0001, 1'b1,
              8'h00, 16'h0003, 8'h00);
        for (int i = 0; i < 5; i++) begin
            if (i == 2)
                applyStimulus(1'b1, 2'b11, 16'h5555, 16'h1111, 8'h00);
            else
                applyStimulus(1'b0, 2'b00, 16'h0000, 16'h0000, 8'h00);
            tick();
            checkOutput("bp.hold.valid", {15'h0, res_valid}, 16'h0001);
            checkOutput("bp.hold.q", res_q, 16'h0003);
            checkOutput("bp.hold.busy", {15'h0, start_ready}, 16'h0000);
        end
        applyStimulus(1'b0, 2'b00, 16'h0000, 16'h0000, 8'h00);
        consumeResult("bp");
        tick();
        checkOutput("bp.no_start.ready", {15'h0, start_ready}, 16'h0001);
        checkIdleAlu("bp.no_start");

        $display("[TB] reset during HI");
        applyStimulus(1'b1, 2'b01, 16'hABCD, 16'h1111, 8'h00);
        tick();
        applyStimulus(1'b0, 2'b00, 16'h0000, 16'h0000, 8'h00);
        tick();
        checkOutput("rst_hi.in_hi", {alu_busa, alu_busb}, 16'hAB11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst_hi.ready", {15'h0, start_ready}, 16'h0001);
        checkOutput("rst_hi.valid", {15'h0, res_valid}, 16'h0000);
        checkOutput("rst_hi.q", res_q, 16'h0000);
        checkOutput("rst_hi.f", {8'h00, res_f}, 16'h0000);
        checkIdleAlu("rst_hi");
        tick();
        checkOutput("rst_hi.stays_idle", {15'h0, res_valid}, 16'h0000);

        runOp("post_rst", 2'b00, 16'h0FFF, 16'h0001, 8'h80, 4'b0000, 4'b0001, 1'b1,
              8'hB0, 16'h1000, 8'hA0);
        consumeResult("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
